// File: rtl/fft_vec_drain.sv
// Drains one 16-lane complex vector from the FFT delay buffer and streams it lane by lane.
// Optional BITREV_ORDER_EN selects bit-reversed physical lane order.
module fft_vec_drain #(
    parameter int WIDTH = 9,
    parameter int LANES = 16,
    localparam int LW   = $clog2(LANES)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      buf_empty,
    output logic                      buf_read,
    input  logic [WIDTH*LANES-1:0]    buf_real,
    input  logic [WIDTH*LANES-1:0]    buf_imag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH-1:0]   out_real,
    output logic signed [WIDTH-1:0]   out_imag,
    output logic [LW-1:0]             out_lane,
    output logic                      out_last,
    output logic                      busy,
    output logic [15:0]               vec_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        CAP    = 2'd2,
        STREAM = 2'd3
    } state_t;

    localparam logic [LW-1:0] CNT_LAST = LW'(LANES - 1);

    state_t                  state_q, state_d;
    logic [LW-1:0]           cnt_q, cnt_d;
    logic [15:0]             vcnt_q, vcnt_d;
    logic signed [WIDTH-1:0] hold_re_q [LANES];
    logic signed [WIDTH-1:0] hold_re_d [LANES];
    logic signed [WIDTH-1:0] hold_im_q [LANES];
    logic signed [WIDTH-1:0] hold_im_d [LANES];
    logic [LW-1:0]           phys;
    logic                    streaming;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            vcnt_q    <= '0;
            hold_re_q <= '{default: '0};
            hold_im_q <= '{default: '0};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vcnt_q    <= vcnt_d;
            hold_re_q <= hold_re_d;
            hold_im_q <= hold_im_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vcnt_d    = vcnt_q;
        hold_re_d = hold_re_q;
        hold_im_d = hold_im_q;
        unique case (state_q)
            IDLE: begin
                if (!buf_empty) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = CAP;
            end
            CAP: begin
                // buffer data_out is only meaningful the cycle after the strobe
                for (int i = 0; i < LANES; i++) begin
                    hold_re_d[i] = buf_real[i*WIDTH +: WIDTH];
                    hold_im_d[i] = buf_imag[i*WIDTH +: WIDTH];
                end
                cnt_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (out_ready) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        vcnt_d  = vcnt_q + 16'd1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + LW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef BITREV_ORDER_EN
    always_comb begin
        phys = '0;
        for (int b = 0; b < LW; b++) begin
            phys[b] = cnt_q[LW-1-b];
        end
    end
`else
    always_comb begin
        phys = cnt_q;
    end
`endif

    always_comb begin
        streaming = (state_q == STREAM);
        buf_read  = (state_q == REQ);
        busy      = (state_q != IDLE);
        out_valid = streaming;
        out_real  = streaming ? hold_re_q[phys] : '0;
        out_imag  = streaming ? hold_im_q[phys] : '0;
        out_lane  = streaming ? phys : '0;
        out_last  = streaming && (cnt_q == CNT_LAST);
        vec_count = vcnt_q;
    end

endmodule

// File: tb/tb_fft_vec_drain.sv
// Bench for fft_vec_drain: buffer model, beat scoreboard, directed scenarios.
// Define BITREV_ORDER_EN for both bench and RTL to check bit-reversed order.
module tb_fft_vec_drain;

    localparam int W  = 9;
    localparam int L  = 16;
    localparam int LW = 4;

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
        logic [LW-1:0]       lane;
        logic                last;
        logic                first;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  buf_empty = 1'b1;
    logic                  buf_read;
    logic [W*L-1:0]        buf_real = '0;
    logic [W*L-1:0]        buf_imag = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic signed [W-1:0]   out_real;
    logic signed [W-1:0]   out_imag;
    logic [LW-1:0]         out_lane;
    logic                  out_last;
    logic                  busy;
    logic [15:0]           vec_count;

    fft_vec_drain #(.WIDTH(W), .LANES(L)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .buf_empty (buf_empty),
        .buf_read  (buf_read),
        .buf_real  (buf_real),
        .buf_imag  (buf_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .busy      (busy),
        .vec_count (vec_count)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [W*L-1:0] bq_re[$];
    logic [W*L-1:0] bq_im[$];
    beat_t          exp_q[$];
    int             exp_cnt = 0;
    int             rd_cycs[$];
    int             last_rd = -1;
    int             obs_re[$];
    int             obs_lane[$];
    int             obs_last[$];
    bit             rd_seen = 0;
    bit             chk_en = 0;
    bit             prev_rd = 0;
    bit             prev_stall = 0;
    bit             first_seen = 0;
    beat_t          prev_beat;
    int             ready_mode = 0;
    int             rphase = 0;
    int             lit[16];

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int phys_of(input int c);
        int p;
        p = c;
`ifdef BITREV_ORDER_EN
        p = 0;
        for (int b = 0; b < LW; b++) begin
            p = p * 2 + ((c >> b) & 1);
        end
`endif
        return p;
    endfunction

    function automatic logic [W*L-1:0] mk(input int kind, input bit im);
        logic [W*L-1:0]      v;
        logic signed [W-1:0] e;
        int                  x;
        v = '0;
        for (int k = 0; k < L; k++) begin
            if (kind == 0) x = im ? -k : k;
            else x = ((k * 37 + kind * 53 + (im ? 101 : 0)) % 512) - 256;
            e = W'(x);
            v[k*W +: W] = e;
        end
        return v;
    endfunction

    task automatic push_vec(input int kind);
        bq_re.push_back(mk(kind, 1'b0));
        bq_im.push_back(mk(kind, 1'b1));
        buf_empty = 1'b0;
    endtask

    task automatic wait_cnt(input int tgt, input int budget);
        int n;
        n = 0;
        while (exp_cnt < tgt && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", int'(exp_cnt >= tgt), 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = (ready_mode == 0) ? 1'b1 : (rphase % 3 == 0);
        rphase++;
    end

    // buffer drives registered data only the cycle after a read, zeros otherwise
    always @(posedge clk) begin
        #1;
        if (rd_seen && bq_re.size() > 0) begin
            rd_seen  = 0;
            buf_real = bq_re.pop_front();
            buf_imag = bq_im.pop_front();
            buf_empty = (bq_re.size() == 0);
            for (int c = 0; c < L; c++) begin
                beat_t bt;
                int    p;
                p        = phys_of(c);
                bt.re    = buf_real[p*W +: W];
                bt.im    = buf_imag[p*W +: W];
                bt.lane  = LW'(p);
                bt.last  = (c == L - 1);
                bt.first = (c == 0);
                exp_q.push_back(bt);
            end
        end else begin
            rd_seen  = 0;
            buf_real = '0;
            buf_imag = '0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rstn) begin
            chk("vec_count", int'(vec_count), exp_cnt);
            if (buf_read) begin
                chk("read_pulse_len", int'(prev_rd), 0);
                chk("no_prefetch", exp_q.size(), 0);
                chk("read_nonempty", int'(bq_re.size() > 0), 1);
                rd_cycs.push_back(cyc);
                last_rd = cyc;
                rd_seen = 1;
            end
            prev_rd = buf_read;
            if (prev_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_real", int'(out_real), int'(prev_beat.re));
                chk("stall_imag", int'(out_imag), int'(prev_beat.im));
                chk("stall_lane", int'(out_lane), int'(prev_beat.lane));
                chk("stall_last", int'(out_last), int'(prev_beat.last));
            end
            if (out_valid) begin
                chk("beat_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    beat_t h;
                    h = exp_q[0];
                    if (h.first && !first_seen) begin
                        chk("read_to_valid", cyc - last_rd, 2);
                        first_seen = 1;
                    end
                    chk("out_real", int'(out_real), int'(h.re));
                    chk("out_imag", int'(out_imag), int'(h.im));
                    chk("out_lane", int'(out_lane), int'(h.lane));
                    chk("out_last", int'(out_last), int'(h.last));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        obs_re.push_back(int'(out_real));
                        obs_lane.push_back(int'(out_lane));
                        obs_last.push_back(int'(out_last));
                        first_seen = 0;
                        if (h.last) exp_cnt++;
                    end
                end
            end
            prev_stall          = out_valid && !out_ready;
            prev_beat.re        = out_real;
            prev_beat.im        = out_imag;
            prev_beat.lane      = out_lane;
            prev_beat.last      = out_last;
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_buf_read"}, int'(buf_read), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_real"}, int'(out_real), 0);
        chk({tag, "_out_imag"}, int'(out_imag), 0);
        chk({tag, "_out_lane"}, int'(out_lane), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_vec_count"}, int'(vec_count), 0);
    endtask

    task automatic chk_order(input string tag);
        chk({tag, "_beats"}, obs_re.size(), 16);
        if (obs_re.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk({tag, "_real_order"}, obs_re[i], lit[i]);
                chk({tag, "_lane_order"}, obs_lane[i], lit[i]);
            end
            chk({tag, "_last_on_16"}, obs_last[15], 1);
            chk({tag, "_not_last_15"}, obs_last[14], 0);
        end
    endtask

    task automatic clear_obs();
        obs_re.delete();
        obs_lane.delete();
        obs_last.delete();
        rd_cycs.delete();
    endtask

    initial begin
`ifdef BITREV_ORDER_EN
        lit = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
        lit = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
        repeat (3) @(posedge clk);
        #2;
        chk_zero("reset");
        rstn = 1'b1;
        chk_en = 1;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            chk("idle_buf_read", int'(buf_read), 0);
            chk("idle_out_valid", int'(out_valid), 0);
            chk("idle_busy", int'(busy), 0);
        end

        clear_obs();
        ready_mode = 0;
        push_vec(0);
        wait_cnt(1, 100);
        repeat (2) @(posedge clk);
        #2;
        chk("single_busy_done", int'(busy), 0);
        chk("single_vec_count", int'(vec_count), 1);
        chk_order("single");

        clear_obs();
        ready_mode = 1;
        push_vec(0);
        wait_cnt(2, 300);
        chk_order("stalled");
        chk("stalled_reads", rd_cycs.size(), 1);
        ready_mode = 0;
        repeat (2) @(posedge clk);

        clear_obs();
        push_vec(1);
        push_vec(2);
        push_vec(3);
        wait_cnt(5, 300);
        chk("burst_reads", rd_cycs.size(), 3);
        if (rd_cycs.size() == 3) begin
            chk("burst_gap_1", rd_cycs[1] - rd_cycs[0], 19);
            chk("burst_gap_2", rd_cycs[2] - rd_cycs[1], 19);
        end
        chk("burst_beats", obs_re.size(), 48);
        repeat (2) @(posedge clk);
        #2;
        chk("burst_vec_count", int'(vec_count), 5);

        clear_obs();
        push_vec(0);
        for (int n = 0; n < 100 && obs_re.size() < 4; n++) @(posedge clk);
        chk("mid_reset_reach", int'(obs_re.size() >= 4), 1);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        chk_en = 0;
        #1;
        chk_zero("async_reset");
        exp_q.delete();
        exp_cnt = 0;
        prev_rd = 0;
        prev_stall = 0;
        first_seen = 0;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        chk_en = 1;
        @(posedge clk);
        #2;
        chk("post_reset_count", int'(vec_count), 0);
        chk("post_reset_busy", int'(busy), 0);
        clear_obs();
        push_vec(0);
        wait_cnt(1, 100);
        chk("post_reset_beats", obs_lane.size(), 16);
        if (obs_lane.size() > 0) chk("post_reset_lane0", obs_lane[0], 0);
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
